id_ex_stage: RTL

//  Stage-3 entry of the MIPS pipeline: ID/EX pipeline register plus load-use hazard unit.
//  - Captures decode data and control-unit signals each cycle; presents them to Execute.
//  - Inserts one bubble and raises stall (holds PC and IF/ID) on a load-use hazard.
//  - Inserts a bubble on flush (taken branch resolved downstream).

---
 rtl/id_ex_stage_if.sv | 65 ++++++
 rtl/id_ex_stage.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decode-side data and control inputs, plus the
// registered Execute-side copies and the combinational stall back to IF/ID.
interface id_ex_stage_if #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 3
);
    // Decode side
    logic               flush;
    logic               id_valid;
    logic [DATA_W-1:0]  next_pc;
    logic [DATA_W-1:0]  read_data1;
    logic [DATA_W-1:0]  read_data2;
    logic [DATA_W-1:0]  sign_ext_imm;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   rd;
    logic               RegDst;
    logic               ALUSrc;
    logic               MemtoReg;
    logic               RegWrite;
    logic               MemRead;
    logic               MemWrite;
    logic               Branch;
    logic [ALUOP_W-1:0] ALUOp;

    // Execute side
    logic               stall;
    logic               ex_valid;
    logic [DATA_W-1:0]  ex_next_pc;
    logic [DATA_W-1:0]  ex_read_data1;
    logic [DATA_W-1:0]  ex_read_data2;
    logic [DATA_W-1:0]  ex_sign_ext_imm;
    logic [REG_W-1:0]   ex_rs;
    logic [REG_W-1:0]   ex_rt;
    logic [REG_W-1:0]   ex_rd;
    logic               ex_RegDst;
    logic               ex_ALUSrc;
    logic               ex_MemtoReg;
    logic               ex_RegWrite;
    logic               ex_MemRead;
    logic               ex_MemWrite;
    logic               ex_Branch;
    logic [ALUOP_W-1:0] ex_ALUOp;

    modport master (
        output flush, id_valid, next_pc, read_data1, read_data2, sign_ext_imm,
               rs, rt, rd, RegDst, ALUSrc, MemtoReg, RegWrite, MemRead,
               MemWrite, Branch, ALUOp,
        input  stall, ex_valid, ex_next_pc, ex_read_data1, ex_read_data2,
               ex_sign_ext_imm, ex_rs, ex_rt, ex_rd, ex_RegDst, ex_ALUSrc,
               ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch,
               ex_ALUOp
    );

    modport slave (
        input  flush, id_valid, next_pc, read_data1, read_data2, sign_ext_imm,
               rs, rt, rd, RegDst, ALUSrc, MemtoReg, RegWrite, MemRead,
               MemWrite, Branch, ALUOp,
        output stall, ex_valid, ex_next_pc, ex_read_data1, ex_read_data2,
               ex_sign_ext_imm, ex_rs, ex_rt, ex_rd, ex_RegDst, ex_ALUSrc,
               ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch,
               ex_ALUOp
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// A load in EX whose destination (rt, non-zero) is read by the valid
// instruction in ID raises stall for one cycle and loads a bubble; flush or an
// empty ID slot also loads a bubble. Optional macro HAZARD_STATS_EN adds
// saturating stall/flush/bubble event counters.
module id_ex_stage #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 3
) (
    input  logic         clk,
    input  logic         rst,
    id_ex_stage_if.slave bus
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]  stall_cnt,
    output logic [31:0]  flush_cnt,
    output logic [31:0]  bubble_cnt
`endif
);

    logic [DATA_W-1:0]  r_ex_next_pc;
    logic [DATA_W-1:0]  r_ex_read_data1;
    logic [DATA_W-1:0]  r_ex_read_data2;
    logic [DATA_W-1:0]  r_ex_sign_ext_imm;
    logic [REG_W-1:0]   r_ex_rs;
    logic [REG_W-1:0]   r_ex_rt;
    logic [REG_W-1:0]   r_ex_rd;
    logic               r_ex_valid;
    logic               r_ex_RegDst;
    logic               r_ex_ALUSrc;
    logic               r_ex_MemtoReg;
    logic               r_ex_RegWrite;
    logic               r_ex_MemRead;
    logic               r_ex_MemWrite;
    logic               r_ex_Branch;
    logic [ALUOP_W-1:0] r_ex_ALUOp;

    logic w_haz;
    logic w_stall;
    logic w_bubble;

    // $0 is hard-wired to zero, so a load targeting it can never feed a consumer.
    assign w_haz = r_ex_valid & r_ex_MemRead & (r_ex_rt != '0) & bus.id_valid
                 & ((r_ex_rt == bus.rs) | (r_ex_rt == bus.rt));

    // A flush discards IF/ID upstream, so holding it would be pointless.
    assign w_stall  = w_haz & ~bus.flush & ~rst;
    assign w_bubble = bus.flush | w_haz | ~bus.id_valid;

    // Pipeline register: data always follows ID, control is zeroed for a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_next_pc      <= '0;
            r_ex_read_data1   <= '0;
            r_ex_read_data2   <= '0;
            r_ex_sign_ext_imm <= '0;
            r_ex_rs           <= '0;
            r_ex_rt           <= '0;
            r_ex_rd           <= '0;
            r_ex_valid        <= 1'b0;
            r_ex_RegDst       <= 1'b0;
            r_ex_ALUSrc       <= 1'b0;
            r_ex_MemtoReg     <= 1'b0;
            r_ex_RegWrite     <= 1'b0;
            r_ex_MemRead      <= 1'b0;
            r_ex_MemWrite     <= 1'b0;
            r_ex_Branch       <= 1'b0;
            r_ex_ALUOp        <= '0;
        end else begin
            r_ex_next_pc      <= bus.next_pc;
            r_ex_read_data1   <= bus.read_data1;
            r_ex_read_data2   <= bus.read_data2;
            r_ex_sign_ext_imm <= bus.sign_ext_imm;
            r_ex_rs           <= bus.rs;
            r_ex_rt           <= bus.rt;
            r_ex_rd           <= bus.rd;
            if (w_bubble) begin
                r_ex_valid    <= 1'b0;
                r_ex_RegDst   <= 1'b0;
                r_ex_ALUSrc   <= 1'b0;
                r_ex_MemtoReg <= 1'b0;
                r_ex_RegWrite <= 1'b0;
                r_ex_MemRead  <= 1'b0;
                r_ex_MemWrite <= 1'b0;
                r_ex_Branch   <= 1'b0;
                r_ex_ALUOp    <= '0;
            end else begin
                r_ex_valid    <= 1'b1;
                r_ex_RegDst   <= bus.RegDst;
                r_ex_ALUSrc   <= bus.ALUSrc;
                r_ex_MemtoReg <= bus.MemtoReg;
                r_ex_RegWrite <= bus.RegWrite;
                r_ex_MemRead  <= bus.MemRead;
                r_ex_MemWrite <= bus.MemWrite;
                r_ex_Branch   <= bus.Branch;
                r_ex_ALUOp    <= bus.ALUOp;
            end
        end
    end

    assign bus.stall           = w_stall;
    assign bus.ex_valid        = r_ex_valid;
    assign bus.ex_next_pc      = r_ex_next_pc;
    assign bus.ex_read_data1   = r_ex_read_data1;
    assign bus.ex_read_data2   = r_ex_read_data2;
    assign bus.ex_sign_ext_imm = r_ex_sign_ext_imm;
    assign bus.ex_rs           = r_ex_rs;
    assign bus.ex_rt           = r_ex_rt;
    assign bus.ex_rd           = r_ex_rd;
    assign bus.ex_RegDst       = r_ex_RegDst;
    assign bus.ex_ALUSrc       = r_ex_ALUSrc;
    assign bus.ex_MemtoReg     = r_ex_MemtoReg;
    assign bus.ex_RegWrite     = r_ex_RegWrite;
    assign bus.ex_MemRead      = r_ex_MemRead;
    assign bus.ex_MemWrite     = r_ex_MemWrite;
    assign bus.ex_Branch       = r_ex_Branch;
    assign bus.ex_ALUOp        = r_ex_ALUOp;

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic [31:0] r_bubble_cnt;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    // Event counters; they stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            r_stall_cnt  <= sat_inc(r_stall_cnt, w_stall);
            r_flush_cnt  <= sat_inc(r_flush_cnt, bus.flush);
            r_bubble_cnt <= sat_inc(r_bubble_cnt, w_bubble);
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
